updown_counter_mod: RTL and testbench

//  Parametrised up/down counter; next generation of the team's 4-bit up/down counter.

---
 rtl/updown_counter_mod.sv | 102 ++++++++++
 tb/tb_updown_counter_mod.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/updown_counter_mod.sv
// Parametrised up/down counter with modulus, wrap/saturate mode, clear/load,
// enable prescaler, boundary flags and one-cycle wrap / load-error pulses.
module updown_counter_mod #(
  parameter int WIDTH    = 4,
  parameter int MODULUS  = 16,
  parameter int SATURATE = 0,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             reset_n,   // active-high despite the name
  input  logic             enable,
  input  logic             up_down,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             at_max,
  output logic             at_min,
  output logic             wrap,
  output logic             load_err
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [WIDTH-1:0] MAX_C  = WIDTH'(MODULUS - 1);
  localparam logic [PW-1:0]    PS_MAX = PW'(PRESCALE - 1);

  logic [WIDTH-1:0] count_q, count_d;
  logic [PW-1:0]    pre_q, pre_d;
  logic             wrap_q, wrap_d;
  logic             err_q, err_d;
  logic             step;

  // NOTE: every signal assigned here gets a default first so no latch is inferred.
  always_comb begin
    count_d = count_q;
    pre_d   = pre_q;
    wrap_d  = 1'b0;
    err_d   = 1'b0;
    step    = 1'b0;

    if (clear) begin
      count_d = '0;
      pre_d   = '0;
    end else if (load) begin
      pre_d = '0;
      if (load_val > MAX_C) begin
        count_d = MAX_C;
        err_d   = 1'b1;
      end else begin
        count_d = load_val;
      end
    end else if (enable) begin
      if (pre_q == PS_MAX) begin
        pre_d = '0;
        step  = 1'b1;
      end else begin
        pre_d = pre_q + PW'(1);
      end
    end

    // Range ends either wrap around or hold; both raise the wrap pulse.
    if (step) begin
      if (up_down) begin
        if (count_q != MAX_C) begin
          count_d = count_q + WIDTH'(1);
        end else begin
          wrap_d = 1'b1;
          if (SATURATE == 0) count_d = '0;
        end
      end else begin
        if (count_q != '0) begin
          count_d = count_q - WIDTH'(1);
        end else begin
          wrap_d = 1'b1;
          if (SATURATE == 0) count_d = MAX_C;
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      count_q <= '0;
      pre_q   <= '0;
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      pre_q   <= pre_d;
      wrap_q  <= wrap_d;
      err_q   <= err_d;
    end
  end

  assign count    = count_q;
  assign at_max   = (count_q == MAX_C);
  assign at_min   = (count_q == '0);
  assign wrap     = wrap_q;
  assign load_err = err_q;

endmodule

// File: tb/tb_updown_counter_mod.sv
// Directed bench for updown_counter_mod: five parameterisations share one
// stimulus bus; each directed section checks the instance it targets.
module tb_updown_counter_mod;

  logic       clk = 1'b0;
  logic       reset_n, enable, up_down, clear, load;
  logic [7:0] load_val;

  logic [3:0] cnt0, cnt1, cnt2, cnt3;
  logic [7:0] cnt4;
  logic       mx0, mx1, mx2, mx3, mx4;
  logic       mn0, mn1, mn2, mn3, mn4;
  logic       wr0, wr1, wr2, wr3, wr4;
  logic       le0, le1, le2, le3, le4;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  updown_counter_mod u0 (
    .clk(clk), .reset_n(reset_n), .enable(enable), .up_down(up_down), .clear(clear),
    .load(load), .load_val(load_val[3:0]), .count(cnt0), .at_max(mx0), .at_min(mn0),
    .wrap(wr0), .load_err(le0));

  updown_counter_mod #(.MODULUS(10)) u1 (
    .clk(clk), .reset_n(reset_n), .enable(enable), .up_down(up_down), .clear(clear),
    .load(load), .load_val(load_val[3:0]), .count(cnt1), .at_max(mx1), .at_min(mn1),
    .wrap(wr1), .load_err(le1));

  updown_counter_mod #(.MODULUS(10), .SATURATE(1)) u2 (
    .clk(clk), .reset_n(reset_n), .enable(enable), .up_down(up_down), .clear(clear),
    .load(load), .load_val(load_val[3:0]), .count(cnt2), .at_max(mx2), .at_min(mn2),
    .wrap(wr2), .load_err(le2));

  updown_counter_mod #(.PRESCALE(3)) u3 (
    .clk(clk), .reset_n(reset_n), .enable(enable), .up_down(up_down), .clear(clear),
    .load(load), .load_val(load_val[3:0]), .count(cnt3), .at_max(mx3), .at_min(mn3),
    .wrap(wr3), .load_err(le3));

  updown_counter_mod #(.WIDTH(8), .MODULUS(256)) u4 (
    .clk(clk), .reset_n(reset_n), .enable(enable), .up_down(up_down), .clear(clear),
    .load(load), .load_val(load_val), .count(cnt4), .at_max(mx4), .at_min(mn4),
    .wrap(wr4), .load_err(le4));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and sample 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse reset between edges and return all inputs to idle.
  task automatic pulse_reset();
    reset_n = 1'b1;
    enable = 1'b0; up_down = 1'b1; clear = 1'b0; load = 1'b0; load_val = '0;
    #3;
    reset_n = 1'b0;
  endtask

  // PRESCALE=3 stimulus: enable pattern and count after each edge
  localparam logic [10:0] PS_EN = 11'b111_1100_1111;  // bit 0 = first edge
  localparam int PS_CNT [11] = '{0, 0, 1, 1, 1, 1, 1, 2, 2, 2, 3};

  initial begin
    reset_n = 1'b1;
    enable = 1'b0; up_down = 1'b1; clear = 1'b0; load = 1'b0; load_val = '0;
    #12;
    reset_n = 1'b0;

    // Reset state on every instance
    check("rst_cnt0", cnt0, 0); check("rst_cnt1", cnt1, 0); check("rst_cnt2", cnt2, 0);
    check("rst_cnt3", cnt3, 0); check("rst_cnt4", cnt4, 0);
    check("rst_min", {mn4, mn3, mn2, mn1, mn0}, 5'b11111);
    check("rst_max", {mx4, mx3, mx2, mx1, mx0}, 5'b00000);
    check("rst_wrap", {wr4, wr3, wr2, wr1, wr0}, 5'b00000);
    check("rst_lerr", {le4, le3, le2, le1, le0}, 5'b00000);

    // 1: defaults, async reset mid-count at 7
    enable = 1'b1; up_down = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    check("t1_cnt7", cnt0, 7);
    #2;
    reset_n = 1'b1;
    #1;
    check("t1_async_rst", cnt0, 0);
    check("t1_async_min", mn0, 1);
    reset_n = 1'b0;
    enable = 1'b0;
    tick();
    check("t1_hold_after_rst", cnt0, 0);

    // 2: MODULUS=10 wrapping up-count for 12 cycles
    pulse_reset();
    enable = 1'b1; up_down = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      check($sformatf("t2_cnt_%0d", i), cnt1, i % 10);
      check($sformatf("t2_wrap_%0d", i), wr1, (i == 10) ? 1 : 0);
      if (i == 9) check("t2_at_max", mx1, 1);
    end

    // 3: MODULUS=10 saturating, 3 down steps from 1
    pulse_reset();
    load = 1'b1; load_val = 8'd1;
    tick();
    check("t3_load1", cnt2, 1);
    load = 1'b0; enable = 1'b1; up_down = 1'b0;
    tick();
    check("t3_s1_cnt", cnt2, 0); check("t3_s1_wrap", wr2, 0);
    tick();
    check("t3_s2_cnt", cnt2, 0); check("t3_s2_wrap", wr2, 1);
    tick();
    check("t3_s3_cnt", cnt2, 0); check("t3_s3_wrap", wr2, 1);
    check("t3_at_min", mn2, 1);
    enable = 1'b0;
    tick();
    check("t3_wrap_low", wr2, 0);

    // 4: PRESCALE=3, enable dropped for 2 cycles after the 4th enabled cycle
    pulse_reset();
    up_down = 1'b1;
    for (int i = 0; i < 11; i++) begin
      enable = PS_EN[i];
      tick();
      check($sformatf("t4_cnt_%0d", i), cnt3, PS_CNT[i]);
    end
    enable = 1'b0;

    // 5: MODULUS=10 out-of-range load, then clear+load
    pulse_reset();
    load = 1'b1; load_val = 8'd12;
    tick();
    check("t5_cnt", cnt1, 9); check("t5_lerr", le1, 1); check("t5_at_max", mx1, 1);
    load = 1'b0;
    tick();
    check("t5_lerr_pulse", le1, 0); check("t5_cnt_hold", cnt1, 9);
    load = 1'b1; clear = 1'b1; load_val = 8'd12;
    tick();
    check("t5_clr_cnt", cnt1, 0); check("t5_clr_lerr", le1, 0);
    load = 1'b0; clear = 1'b0;

    // 6: WIDTH=8 MODULUS=256 wrap both directions
    pulse_reset();
    load = 1'b1; load_val = 8'd255;
    tick();
    check("t6_load", cnt4, 255); check("t6_at_max", mx4, 1); check("t6_lerr", le4, 0);
    load = 1'b0; enable = 1'b1; up_down = 1'b1;
    tick();
    check("t6_up_cnt", cnt4, 0); check("t6_up_wrap", wr4, 1);
    up_down = 1'b0;
    tick();
    check("t6_dn_cnt", cnt4, 255); check("t6_dn_wrap", wr4, 1);
    enable = 1'b0;
    tick();
    check("t6_wrap_low", wr4, 0); check("t6_hold", cnt4, 255);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
